// File: rtl/water_district.sv
// Water district cistern controller: serves demand, requests refills, rations on repeated shortages.
// Optional energy accumulator enabled by defining WATER_DISTRICT_ENERGY_EN.
module water_district #(
   parameter logic [7:0]  CAP       = 8'd64,
   parameter logic [7:0]  TARGET    = 8'd32,
   parameter int unsigned RATION_TH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  usage,
   input  logic [7:0]  supply,
   input  logic [7:0]  power,
   output logic [7:0]  req,
   output logic [7:0]  level,
   output logic [7:0]  served,
   output logic        spill,
   output logic [7:0]  shortfall,
   output logic [1:0]  state,
   output logic [15:0] energy
);
   typedef enum logic [1:0] {IDLE = 2'd0, NORMAL = 2'd1, RATION = 2'd2, RECOVER = 2'd3} state_t;

   state_t     state_q, state_d;
   logic [7:0] req_q, req_d, level_q, level_d, served_q, served_d, shortfall_q, shortfall_d;
   logic       spill_q, spill_d;
   logic [3:0] consec_q, consec_d;
   logic [2:0] clean_q, clean_d;
   logic [7:0] usage_eff, deficit;
   logic [8:0] avail, remain, need_sum;
   logic [5:0] need;
   logic       short_cyc;

   always_comb begin
      // A district waking from IDLE with en=1 serves demand at full rate that same cycle.
      usage_eff = 8'd0;
      if (en) begin
         if (state_q == RATION) usage_eff = {1'b0, usage[7:1]};
         else                   usage_eff = usage;
      end
      avail    = {1'b0, level_q} + {1'b0, supply};
      served_d = ({1'b0, usage_eff} < avail) ? usage_eff : avail[7:0];
      remain   = avail - {1'b0, served_d};
      spill_d  = remain > {1'b0, CAP};
      level_d  = spill_d ? CAP : remain[7:0];
      deficit  = (TARGET > level_d) ? (TARGET - level_d) : 8'd0;
      need_sum = {1'b0, deficit} + {1'b0, usage_eff};
      need     = (need_sum > 9'd63) ? 6'd63 : need_sum[5:0];
      req_d    = en ? {need, 2'b00} : 8'd0;

      short_cyc   = en && (served_d < usage_eff);
      shortfall_d = (short_cyc && shortfall_q != 8'hFF) ? shortfall_q + 8'd1 : shortfall_q;
      consec_d    = short_cyc ? ((consec_q == 4'hF) ? consec_q : consec_q + 4'd1) : 4'd0;

      // Clean count only survives while staying in RECOVER, so entry always starts from zero.
      clean_d = 3'd0;
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = NORMAL;
            NORMAL:  if (32'(consec_d) >= RATION_TH) state_d = RATION;
            RATION:  if (level_d >= TARGET) state_d = RECOVER;
            RECOVER: begin
               if (short_cyc) begin
                  state_d = RATION;
               end else begin
                  clean_d = clean_q + 3'd1;
                  if (clean_q == 3'd3) state_d = NORMAL;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= 8'd0;
         level_q     <= 8'd0;
         served_q    <= 8'd0;
         spill_q     <= 1'b0;
         shortfall_q <= 8'd0;
         consec_q    <= 4'd0;
         clean_q     <= 3'd0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         level_q     <= level_d;
         served_q    <= served_d;
         spill_q     <= spill_d;
         shortfall_q <= shortfall_d;
         consec_q    <= consec_d;
         clean_q     <= clean_d;
      end
   end

   assign req       = req_q;
   assign level     = level_q;
   assign served    = served_q;
   assign spill     = spill_q;
   assign shortfall = shortfall_q;
   assign state     = state_q;

`ifdef WATER_DISTRICT_ENERGY_EN
   logic [15:0] energy_q, energy_d;
   logic [16:0] energy_sum;

   always_comb begin
      energy_sum = {1'b0, energy_q} + {9'd0, power};
      energy_d   = energy_q;
      if (en) energy_d = energy_sum[16] ? 16'hFFFF : energy_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) energy_q <= 16'd0;
      else     energy_q <= energy_d;
   end

   assign energy = energy_q;
`else
   logic unused_power;
   assign unused_power = ^power;
   assign energy       = 16'h0000;
`endif
endmodule
